clkdiv_prog: RTL and testbench

CLKDIV_PROG -- requirements
Module: clkdiv_prog

---
 rtl/clkdiv_pkg.sv | 6 +
 rtl/clkdiv_edge_det.sv | 18 +
 rtl/clkdiv_prog.sv | 61 ++++++
 tb/tb_clkdiv_prog.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and constants for the programmable clock divider.
package clkdiv_pkg;
  localparam int CNT_W_DEF     = 8;
  localparam int DIV_RESET_DEF = 4;
  localparam int MIN_RATIO     = 2;
endpackage

// File: rtl/clkdiv_edge_det.sv
// clkdiv_edge_det: registered rising-edge detector producing a one-cycle pulse.
module clkdiv_edge_det (
  input  logic hclkin,
  input  logic resetn,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      q     <= 1'b0;
      pulse <= 1'b0;
    end else begin
      q     <= d;
      pulse <= d & ~q;
    end
  end
endmodule

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: programmable divider with glitch-free ratio change at wrap and calib phase slip.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             hclkin,
  input  logic             resetn,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_busy,
  input  logic             calib,
  output logic             clkout,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             locked,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] MIN       = CNT_W'(MIN_RATIO);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  logic [CNT_W-1:0] cnt, ratio, pending, cnt_nxt, ratio_nxt;
  logic hold, wrap, apply, primed;
  clkdiv_edge_det u_edge (.hclkin(hclkin), .resetn(resetn), .d(calib), .pulse(hold));
  always_comb begin
    wrap      = !hold && (cnt == ratio - ONE);
    apply     = wrap && div_busy;
    cnt_nxt   = hold ? cnt : wrap ? '0 : cnt + ONE;
    ratio_nxt = apply ? pending : ratio;
  end
  // Outputs are registered from next-state so they line up with cnt in the same cycle.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      cnt      <= RST_RATIO - ONE;
      ratio    <= RST_RATIO;
      pending  <= RST_RATIO;
      clkout   <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      div_busy <= 1'b0;
      locked   <= 1'b0;
      primed   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ratio    <= ratio_nxt;
      clkout   <= cnt_nxt < (ratio_nxt >> 1);
      rise_stb <= !hold && (cnt_nxt == '0);
      fall_stb <= !hold && (cnt_nxt == (ratio_nxt >> 1));
      if (div_load) pending <= (div_ratio < MIN) ? MIN : div_ratio;
      div_busy <= div_load | (div_busy & ~apply);
      cfg_err  <= cfg_err | (div_load && (div_ratio < MIN));
      // The wrap leaving reset only starts the first period; it cannot prove lock.
      if (wrap) begin
        locked <= primed && !div_busy;
        primed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: scoreboard bench for clkdiv_prog with per-scenario tasks.
module tb_clkdiv_prog;
  logic       hclkin, resetn, div_load, div_busy, calib;
  logic [7:0] div_ratio;
  logic       clkout, rise_stb, fall_stb, locked, cfg_err;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  typedef struct packed {
    logic clk, rs, fs, lk, bz, er;
  } exp_t;
  exp_t sb[$];
  clkdiv_prog #(.CNT_W(8), .DIV_RESET(4)) dut (
    .hclkin(hclkin), .resetn(resetn), .div_ratio(div_ratio), .div_load(div_load),
    .div_busy(div_busy), .calib(calib), .clkout(clkout), .rise_stb(rise_stb),
    .fall_stb(fall_stb), .locked(locked), .cfg_err(cfg_err)
  );
  initial hclkin = 1'b0;
  always #5 hclkin = ~hclkin;
  task automatic push_e(input logic c, input logic r, input logic f, input logic l,
                        input logic b, input logic e);
    exp_t x;
    x.clk = c; x.rs = r; x.fs = f; x.lk = l; x.bz = b; x.er = e;
    sb.push_back(x);
  endtask
  task automatic push_part(input int n, input logic lk, input int bz_from, input int er_from,
                           input int len);
    for (int i = 0; i < len; i++)
      push_e(i < n / 2, i == 0, i == n / 2, lk, i >= bz_from, i >= er_from);
  endtask
  task automatic push_period(input int n, input logic lk, input int bz_from, input int er_from);
    push_part(n, lk, bz_from, er_from, n);
  endtask
  task automatic check_cycle();
    exp_t e, g;
    @(negedge hclkin);
    g = {clkout, rise_stb, fall_stb, locked, div_busy, cfg_err};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL underflow cycle %0d: got %b, no expectation queued", cyc, g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL cycle %0d clk/rise/fall/lock/busy/err: got %b expected %b", cyc, g, e);
      end
    end
    cyc++;
  endtask
  task automatic run(input int k);
    repeat (k) check_cycle();
  endtask
  task automatic test_reset();
    logic [5:0] g;
    resetn = 1'b0; div_ratio = '0; div_load = 1'b0; calib = 1'b0;
    repeat (3) @(negedge hclkin);
    g = {clkout, rise_stb, fall_stb, locked, div_busy, cfg_err};
    checks++;
    if (g !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000000", g);
    end
    push_period(4, 1'b0, 99, 99);
    push_period(4, 1'b1, 99, 99);
    push_period(4, 1'b1, 99, 99);
    resetn = 1'b1;
    run(12);
  endtask
  task automatic test_load();
    push_period(4, 1'b1, 1, 99);
    push_period(5, 1'b0, 99, 99);
    push_period(5, 1'b1, 99, 99);
    run(1);
    div_ratio = 8'd5; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    run(12);
  endtask
  task automatic test_back_to_back();
    push_period(5, 1'b1, 1, 99);
    push_period(8, 1'b0, 99, 99);
    push_period(8, 1'b1, 99, 99);
    run(1);
    div_ratio = 8'd6; div_load = 1'b1;
    run(1);
    div_ratio = 8'd8;
    run(1);
    div_load = 1'b0;
    run(18);
  endtask
  task automatic test_cfg_err();
    push_period(8, 1'b1, 1, 1);
    push_period(2, 1'b0, 99, 0);
    repeat (3) push_period(2, 1'b1, 99, 0);
    run(1);
    div_ratio = 8'd1; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    run(14);
    push_period(2, 1'b1, 1, 0);
    push_period(4, 1'b0, 99, 0);
    push_period(4, 1'b1, 99, 0);
    run(1);
    div_ratio = 8'd4; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    run(8);
  endtask
  task automatic push_slip_mid();
    push_e(1, 1, 0, 1, 0, 1);
    push_e(1, 0, 0, 1, 0, 1);
    push_e(1, 0, 0, 1, 0, 1);
    push_e(0, 0, 1, 1, 0, 1);
    push_e(0, 0, 0, 1, 0, 1);
  endtask
  task automatic test_calib();
    push_slip_mid();
    push_period(4, 1'b1, 99, 0);
    run(1);
    calib = 1'b1;
    run(1);
    calib = 1'b0;
    run(7);
    push_slip_mid();
    repeat (3) push_period(4, 1'b1, 99, 0);
    run(1);
    calib = 1'b1;
    run(10);
    calib = 1'b0;
    run(6);
    push_e(1, 1, 0, 1, 0, 1);
    push_e(1, 0, 0, 1, 0, 1);
    push_e(0, 0, 1, 1, 0, 1);
    push_e(0, 0, 0, 1, 0, 1);
    push_e(0, 0, 0, 1, 0, 1);
    push_period(4, 1'b1, 99, 0);
    run(3);
    calib = 1'b1;
    run(1);
    calib = 1'b0;
    run(5);
  endtask
  task automatic test_reset_pending();
    logic [5:0] g;
    push_part(4, 1'b1, 1, 0, 3);
    run(1);
    div_ratio = 8'd6; div_load = 1'b1;
    run(1);
    div_load = 1'b0;
    run(1);
    resetn = 1'b0;
    #1;
    g = {clkout, rise_stb, fall_stb, locked, div_busy, cfg_err};
    checks++;
    if (g !== 6'b0) begin
      errors++;
      $display("FAIL reset_pending_state: got %b expected 000000", g);
    end
    repeat (2) @(negedge hclkin);
    push_period(4, 1'b0, 99, 99);
    push_period(4, 1'b1, 99, 99);
    push_period(4, 1'b1, 99, 99);
    resetn = 1'b1;
    run(12);
  endtask
  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_cfg_err();
    test_calib();
    test_reset_pending();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
